// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the sprite drawing path of the space invaders game.
package space_invaders_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned SPRITE_DIM = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  localparam int unsigned REQ_PLAYER  = 0;
  localparam int unsigned REQ_ALIEN   = 1;
  localparam int unsigned REQ_PBULLET = 2;
  localparam int unsigned REQ_ABULLET = 3;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StDraw,
    StDone
  } sched_state_e;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester-side bundle of the sprite draw scheduler: per-requester jobs in, acks out.
interface sprite_draw_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_erase;
  logic [8*N_REQ-1:0] req_x;
  logic [7*N_REQ-1:0] req_y;
  logic [8*N_REQ-1:0] req_old_x;
  logic [7*N_REQ-1:0] req_old_y;
  logic [3*N_REQ-1:0] req_colour;
  logic [N_REQ-1:0]   ack;

  modport master (
    output req, req_erase, req_x, req_y, req_old_x, req_old_y, req_colour,
    input  ack
  );

  modport slave (
    input  req, req_erase, req_x, req_y, req_old_x, req_old_y, req_colour,
    output ack
  );
endinterface

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PtrW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PtrW-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PtrW-1:0]  grant_idx,
  output logic             grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = PtrW'(idx);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares the VGA plot port among sprite requesters; sequences 4x4 erase and draw sweeps.
module sprite_draw_scheduler
  import space_invaders_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SCREEN_W = space_invaders_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = space_invaders_pkg::SCREEN_H
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sprite_draw_scheduler_if.slave bus,
  output logic                   busy,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(SPRITE_DIM * SPRITE_DIM);
  localparam logic [CntW-1:0] CntLast = CntW'(SPRITE_DIM * SPRITE_DIM - 1);

  sched_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  gnt_idx_q;
  logic [N_REQ-1:0] gnt_q;
  logic [7:0]       x_q, old_x_q;
  logic [6:0]       y_q, old_y_q;
  logic [2:0]       colour_q;

  logic [N_REQ-1:0] arb_grant;
  logic [PtrW-1:0]  arb_idx;
  logic             arb_valid;
  logic             latch_en;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req        (bus.req),
    .ptr        (ptr_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          state_d  = bus.req_erase[arb_idx] ? StErase : StDraw;
        end
      end
      StErase: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = (gnt_idx_q == PtrW'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      old_x_q   <= '0;
      old_y_q   <= '0;
      colour_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      if (latch_en) begin
        gnt_idx_q <= arb_idx;
        gnt_q     <= arb_grant;
        x_q       <= bus.req_x[8*arb_idx +: 8];
        y_q       <= bus.req_y[7*arb_idx +: 7];
        old_x_q   <= bus.req_old_x[8*arb_idx +: 8];
        old_y_q   <= bus.req_old_y[7*arb_idx +: 7];
        colour_q  <= bus.req_colour[3*arb_idx +: 3];
      end
    end
  end

  // Sums are one bit wider than the coordinate so off-screen pixels never wrap back on.
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       sweeping;
  logic       on_screen;

  always_comb begin
    sweeping = (state_q == StErase) || (state_q == StDraw);
    if (state_q == StErase) begin
      sum_x = {1'b0, old_x_q} + {7'b0, cnt_q[1:0]};
      sum_y = {1'b0, old_y_q} + {6'b0, cnt_q[3:2]};
    end else begin
      sum_x = {1'b0, x_q} + {7'b0, cnt_q[1:0]};
      sum_y = {1'b0, y_q} + {6'b0, cnt_q[3:2]};
    end
    on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

    vga_plot   = sweeping && on_screen;
    vga_x      = sweeping ? sum_x[7:0] : '0;
    vga_y      = sweeping ? sum_y[6:0] : '0;
    vga_colour = (state_q == StDraw) ? colour_q : COLOUR_BLACK;
    busy       = (state_q != StIdle);
    bus.ack    = (state_q == StDone) ? gnt_q : '0;
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: sweep order, latency, arbitration, clipping, reset.
module tb_sprite_draw_scheduler;
  import space_invaders_pkg::*;

  localparam int unsigned NR = 4;

  logic       clk;
  logic       reset_n;
  logic       busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  sprite_draw_scheduler_if #(.N_REQ(NR)) bus ();

  sprite_draw_scheduler #(
    .N_REQ(NR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int col;
    int cyc;
  } plot_t;

  plot_t plots[$];
  int    ack_idx[$];
  int    ack_cyc[$];

  function automatic int q_get(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic set_op(input int i, input int x, input int y, input int ox, input int oy,
                        input int col, input bit erase);
    bus.req_x[8*i +: 8]      = 8'(x);
    bus.req_y[7*i +: 7]      = 7'(y);
    bus.req_old_x[8*i +: 8]  = 8'(ox);
    bus.req_old_y[7*i +: 7]  = 7'(oy);
    bus.req_colour[3*i +: 3] = 3'(col);
    bus.req_erase[i]         = erase;
  endtask

  // Samples on negedges, drops each req on its ack, optionally perturbs x/y mid-job.
  task automatic run_jobs(input int n_acks, input int budget, input int change_at);
    int n;
    n = 0;
    plots.delete();
    ack_idx.delete();
    ack_cyc.delete();
    for (int c = 0; c < budget && n < n_acks; c++) begin
      @(negedge clk);
      if (vga_plot) plots.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
      for (int i = 0; i < int'(NR); i++) begin
        if (bus.ack[i]) begin
          ack_idx.push_back(i);
          ack_cyc.push_back(cyc);
          bus.req[i] = 1'b0;
          n++;
        end
      end
      if (change_at >= 0 && plots.size() == change_at) begin
        bus.req_x = {NR{8'd100}};
        bus.req_y = {NR{7'd90}};
      end
    end
    check("ack_count", n, n_acks);
  endtask

  task automatic check_sweep(input string tag, input int first, input int x0, input int y0,
                             input int col);
    for (int k = 0; k < 16; k++) begin
      int p;
      p = first + k;
      if (p < plots.size()) begin
        check({tag, "_x"}, plots[p].x, x0 + k % 4);
        check({tag, "_y"}, plots[p].y, y0 + k / 4);
        check({tag, "_col"}, plots[p].col, col);
      end
    end
  endtask

  int e0;
  int n;

  initial begin
    reset_n        = 1'b0;
    bus.req        = '0;
    bus.req_erase  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_old_x  = '0;
    bus.req_old_y  = '0;
    bus.req_colour = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single draw, no erase
    set_op(REQ_PLAYER, 78, 100, 0, 0, 7, 1'b0);
    bus.req[REQ_PLAYER] = 1'b1;
    e0 = cyc + 1;
    run_jobs(1, 60, -1);
    check("single_nplots", plots.size(), 16);
    check_sweep("single", 0, 78, 100, 7);
    check("single_first_cyc", (plots.size() > 0) ? plots[0].cyc : -1, e0);
    check("single_ack_idx", q_get(ack_idx, 0), REQ_PLAYER);
    check("single_ack_cyc", q_get(ack_cyc, 0), e0 + 16);
    repeat (2) @(negedge clk);

    // Erase old position then draw new one
    set_op(REQ_ALIEN, 11, 20, 10, 20, 5, 1'b1);
    bus.req[REQ_ALIEN] = 1'b1;
    e0 = cyc + 1;
    run_jobs(1, 80, -1);
    check("erase_nplots", plots.size(), 32);
    check_sweep("erase", 0, 10, 20, 0);
    check_sweep("redraw", 16, 11, 20, 5);
    check("erase_ack_idx", q_get(ack_idx, 0), REQ_ALIEN);
    check("erase_ack_cyc", q_get(ack_cyc, 0), e0 + 32);
    check("erase_busy_idle", int'(busy), 1);
    repeat (2) @(negedge clk);

    // Contention from pointer 0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(NR); i++) set_op(i, 4 * i, 10, 0, 0, i + 1, 1'b0);
    bus.req = '1;
    e0 = cyc + 1;
    run_jobs(4, 200, -1);
    check("cont_nplots", plots.size(), 64);
    for (int i = 0; i < int'(NR); i++) check("cont_order", q_get(ack_idx, i), i);
    check("cont_first_ack", q_get(ack_cyc, 0), e0 + 16);
    check("cont_spacing", q_get(ack_cyc, 1) - q_get(ack_cyc, 0), 18);
    check("cont_spacing3", q_get(ack_cyc, 3) - q_get(ack_cyc, 2), 18);
    repeat (2) @(negedge clk);
    bus.req[REQ_ABULLET] = 1'b1;
    bus.req[REQ_PLAYER]  = 1'b1;
    run_jobs(2, 100, -1);
    check("rearb_first", q_get(ack_idx, 0), REQ_PLAYER);
    check("rearb_second", q_get(ack_idx, 1), REQ_ABULLET);
    repeat (2) @(negedge clk);

    // Clipping at bottom-right corner
    set_op(REQ_PLAYER, 158, 118, 0, 0, 6, 1'b0);
    bus.req[REQ_PLAYER] = 1'b1;
    e0 = cyc + 1;
    run_jobs(1, 60, -1);
    check("clip_nplots", plots.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < plots.size()) begin
        check("clip_x", plots[k].x, 158 + k % 2);
        check("clip_y", plots[k].y, 118 + k / 2);
      end
    end
    check("clip_ack_cyc", q_get(ack_cyc, 0), e0 + 16);
    repeat (2) @(negedge clk);

    // Reset at DRAW cnt=7, pointer currently 1
    set_op(REQ_PBULLET, 20, 30, 0, 0, 2, 1'b0);
    bus.req[REQ_PBULLET] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (vga_plot) n++;
    end
    check("rstmid_reach", n, 8);
    check("rstmid_x_cnt7", int'(vga_x), 23);
    reset_n = 1'b0;
    set_op(REQ_PLAYER, 50, 50, 0, 0, 1, 1'b0);
    bus.req[REQ_PLAYER] = 1'b1;
    @(negedge clk);
    check("rstmid_plot", int'(vga_plot), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_ack", int'(bus.ack), 0);
    reset_n = 1'b1;
    run_jobs(2, 100, -1);
    check("rstmid_grant0", q_get(ack_idx, 0), REQ_PLAYER);
    check("rstmid_grant1", q_get(ack_idx, 1), REQ_PBULLET);
    check("rstmid_nplots", plots.size(), 32);
    repeat (2) @(negedge clk);

    // Operands change during DRAW
    set_op(REQ_ALIEN, 40, 50, 0, 0, 3, 1'b0);
    bus.req[REQ_ALIEN] = 1'b1;
    run_jobs(1, 60, 4);
    check("opchg_nplots", plots.size(), 16);
    check_sweep("opchg", 0, 40, 50, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Shares the single VGA plot port (160x120, 3-bit colour) among N sprite requesters: player, alien group, player bullet and alien bullet.
- Each requester asks for a 4x4 sprite to be drawn at a new position, optionally erasing its old position first.
- The block arbitrates round-robin and sequences the 16-pixel erase and draw sweeps.
- It pulses a per-requester ack when that requester's job is complete.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low; clock clk.
- req  in  N_REQ  per-requester draw request, level; held until ack.
- req_erase  in  N_REQ  1 = erase the old position (black) before drawing.
- req_x  in  8*N_REQ  new top-left x per requester, packed with requester i at [8i+7:8i].
- req_y  in  7*N_REQ  new top-left y, packed the same way.
- req_old_x  in  8*N_REQ  old top-left x, used only when req_erase is set.
- req_old_y  in  7*N_REQ  old top-left y, used only when req_erase is set.
- req_colour  in  3*N_REQ  draw colour.
- ack  out  N_REQ  one-cycle completion pulse for the granted requester.
- busy  out  1  high whenever state is not IDLE.
- vga_x  out  8  pixel x to the VGA adapter.
- vga_y  out  7  pixel y to the VGA adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write enable.

Behaviour:
- States: IDLE, ERASE, DRAW, DONE.
- Reset (reset_n low at a clk edge):
  - state=IDLE, rr pointer=0, pixel counter=0.
  - ack=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - Reset mid-job aborts immediately; no ack is issued and no further pixels are plotted.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - Latch that requester's x, y, old_x, old_y, colour and erase flag; clear the counter.
  - Go to ERASE if the erase flag is set, else DRAW.
  - If no req bit is set, stay in IDLE.
- ERASE:
  - 16 cycles, counter 0..15.
  - Pixel = (old_x + cnt[1:0], old_y + cnt[3:2]), colour 3'b000.
  - After cnt=15: go to DRAW with the counter cleared.
- DRAW:
  - 16 cycles, same sweep at (x, y) with the latched colour.
  - After cnt=15: go to DONE.
- DONE:
  - One cycle; ack[grant]=1.
  - Pointer <= (grant+1) mod N_REQ.
  - Next state IDLE.
- Outputs are decoded from registered state, counter and latched operands only; there is no combinational path from req inputs to vga_* outputs.
- vga_plot=1 only in ERASE/DRAW, and only for on-screen pixels.
- Clipping:
  - Sums are computed at 9 bits (x) and 8 bits (y).
  - A pixel with x >= SCREEN_W or y >= SCREEN_H has vga_plot=0, but the counter still advances (fixed timing).
- Latency, counted from the IDLE grant edge E0:
  - No erase: plot cycles E0..E16; ack during cycle E16..E17; IDLE at E17; earliest next grant at edge E18.
  - With erase: 32 plot cycles; ack 32 cycles after E0.
- Operand stability:
  - Requests are sampled only in IDLE.
  - Changes to req or operands during a job are ignored; the latched values are used throughout.
  - Dropping req mid-job does not cancel the job, and its ack is still issued.
- Handshake:
  - A requester deasserts req on the edge after it sees ack.
  - A req still high in IDLE after its own ack is treated as a new job; the rotated pointer gives other requesters priority first.
- Simultaneous requests are serialised in pointer order; a continuously requesting set of N requesters is each served once per N jobs.
- busy=1 in ERASE, DRAW and DONE.

Decomposition:
- Shared package (space_invaders_pkg):
  - SCREEN_W, SCREEN_H, SPRITE_DIM=4, COLOUR_BLACK=3'b000, COLOUR_WHITE=3'b111.
  - State encoding enum.
  - Requester index constants: REQ_PLAYER=0, REQ_ALIEN=1, REQ_PBULLET=2, REQ_ABULLET=3.
- Sub-module rr_arbiter (combinational): req and pointer in, one-hot grant plus grant index out. Instantiated once.

Test Plan:
- Single job: req[0] with x=78, y=100, colour=7, no erase.
  - Required: exactly 16 plots covering x 78..81, y 100..103 in row-major order, colour 7.
  - ack[0] pulses once, 16 cycles after the grant edge.
- Erase then draw: req[1] with old=(10,20), new=(11,20), colour=5.
  - Required: 16 black plots at x 10..13, y 20..23, then 16 plots of colour 5 at x 11..14.
  - ack[1] after 32 plot cycles.
- Contention: req[0..3] all asserted in the same cycle, each dropped on its ack.
  - Required: grants in order 0,1,2,3; then re-asserting req[3] and req[0] together grants 0 before 3.
- Clipping: req at x=158, y=118.
  - Required: only pixels (158..159, 118..119) are plotted, 4 total.
  - Job still takes 16 cycles and acks normally.
- Reset mid-job: assert reset_n=0 at DRAW cnt=7.
  - Required: next cycle vga_plot=0, busy=0, ack=0.
  - Held req re-granted from pointer 0 after reset releases.
- Operand change mid-job: change req_x during DRAW.
  - Required: plotted x values still use the latched x.
